// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline sequencing bundle: hazard/branch/memory inputs and freeze/flush/status outputs.
interface hazard_stall_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_two_src;
    logic [3:0]       exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [3:0]       mem_dest;
    logic             mem_wb_en;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             clr_stats;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             freeze_id_ex;
    logic             freeze_exe_mem;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             busy_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       state;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src,
        output exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
        output branch_taken, mem_req, mem_ready, clr_stats,
        input  freeze_pc, freeze_if_id, freeze_id_ex, freeze_exe_mem,
        input  flush_if_id, flush_id_ex, busy_err, stall_cnt, flush_cnt, state
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src,
        input  exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
        input  branch_taken, mem_req, mem_ready, clr_stats,
        output freeze_pc, freeze_if_id, freeze_id_ex, freeze_exe_mem,
        output flush_if_id, flush_id_ex, busy_err, stall_cnt, flush_cnt, state
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Freeze/flush sequencing for the 5-stage core with memory-wait watchdog and stats.
// Define FORWARDING_EN to restrict hazards to load-use against EXE.
module hazard_stall_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           cur, nxt;
    logic [7:0]       wait_cnt, wait_nxt;
    logic             src1_hit, src2_hit, hz;
    logic             f_pc, f_ifid, f_idex, f_exmem;
    logic             fl_ifid, fl_idex, branch_flush;
    logic [CNT_W-1:0] stall_q, flush_q;

`ifdef FORWARDING_EN
    assign src1_hit = bus.exe_mem_r_en & bus.exe_wb_en & (bus.exe_dest == bus.id_src1);
    assign src2_hit = bus.exe_mem_r_en & bus.exe_wb_en & (bus.exe_dest == bus.id_src2);
`else
    assign src1_hit = (bus.exe_wb_en & (bus.exe_dest == bus.id_src1)) |
                      (bus.mem_wb_en & (bus.mem_dest == bus.id_src1));
    assign src2_hit = (bus.exe_wb_en & (bus.exe_dest == bus.id_src2)) |
                      (bus.mem_wb_en & (bus.mem_dest == bus.id_src2));
`endif

    assign hz = bus.id_valid & (src1_hit | (bus.id_two_src & src2_hit));

    always_comb begin
        nxt          = cur;
        wait_nxt     = wait_cnt;
        f_pc         = 1'b0;
        f_ifid       = 1'b0;
        f_idex       = 1'b0;
        f_exmem      = 1'b0;
        fl_ifid      = 1'b0;
        fl_idex      = 1'b0;
        branch_flush = 1'b0;
        unique case (cur)
            INIT: begin
                fl_ifid = 1'b1;
                fl_idex = 1'b1;
                nxt     = RUN;
            end
            RUN, MEM_WAIT: begin
                if (bus.mem_req & ~bus.mem_ready) begin
                    {f_pc, f_ifid, f_idex, f_exmem} = '1;
                    if (cur == RUN) begin
                        wait_nxt = 8'd1;
                        nxt      = (TIMEOUT == 1) ? ERROR : MEM_WAIT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        nxt = ERROR;
                    end else begin
                        wait_nxt = wait_cnt + 8'd1;
                    end
                end else begin
                    // Branch beats hazard: the ID instruction is wrong-path anyway.
                    nxt = RUN;
                    if (bus.branch_taken) begin
                        fl_ifid      = 1'b1;
                        fl_idex      = 1'b1;
                        branch_flush = 1'b1;
                    end else if (hz) begin
                        f_pc    = 1'b1;
                        f_ifid  = 1'b1;
                        fl_idex = 1'b1;
                    end
                end
            end
            ERROR: begin
                {f_pc, f_ifid, f_idex, f_exmem} = '1;
            end
            default: nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur      <= INIT;
            wait_cnt <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            cur      <= nxt;
            wait_cnt <= wait_nxt;
            if (bus.clr_stats) begin
                stall_q <= '0;
                flush_q <= '0;
            end else begin
                if (f_pc && (stall_q != '1))
                    stall_q <= stall_q + CNT_W'(1);
                if (branch_flush && (flush_q != '1))
                    flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign bus.freeze_pc      = f_pc;
    assign bus.freeze_if_id   = f_ifid;
    assign bus.freeze_id_ex   = f_idex;
    assign bus.freeze_exe_mem = f_exmem;
    assign bus.flush_if_id    = fl_ifid;
    assign bus.flush_id_ex    = fl_idex;
    assign bus.busy_err       = (cur == ERROR);
    assign bus.stall_cnt      = stall_q;
    assign bus.flush_cnt      = flush_q;
    assign bus.state          = cur;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic vs a rule model.
module tb_hazard_stall_ctrl;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int          CMAX    = (1 << CNT_W) - 1;
    localparam int unsigned VW      = 9 + 2 * CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] obs;
    assign obs = {bus.state, bus.busy_err, bus.freeze_pc, bus.freeze_if_id, bus.freeze_id_ex,
                  bus.freeze_exe_mem, bus.flush_if_id, bus.flush_id_ex, bus.stall_cnt, bus.flush_cnt};

    // Reference model: mode 0 init, 1 run, 2 waiting, 3 error; m_waited = consecutive not-ready cycles.
    int m_mode, m_waited, m_stall, m_flush;
    int n_mode, n_waited, n_stall, n_flush;

    function automatic int sat(int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic bit reads_pending(logic [3:0] r);
`ifdef FORWARDING_EN
        return bus.exe_mem_r_en && bus.exe_wb_en && (bus.exe_dest == r);
`else
        return (bus.exe_wb_en && bus.exe_dest == r) || (bus.mem_wb_en && bus.mem_dest == r);
`endif
    endfunction

    function automatic bit hazard_ref();
        return bus.id_valid && (reads_pending(bus.id_src1) || (bus.id_two_src && reads_pending(bus.id_src2)));
    endfunction

    task automatic predict(output logic [VW-1:0] e);
        logic [5:0] o;
        logic       busy;
        bit         br;
        o = '0; busy = 1'b0; br = 0;
        n_mode = m_mode; n_waited = m_waited;
        if (m_mode == 0) begin
            o = 6'b000011; n_mode = 1;
        end else if (m_mode == 3) begin
            o = 6'b111100; busy = 1'b1;
        end else if (bus.mem_req && !bus.mem_ready) begin
            o = 6'b111100;
            n_waited = (m_mode == 1) ? 1 : m_waited + 1;
            n_mode = (n_waited >= int'(TIMEOUT)) ? 3 : 2;
        end else begin
            n_mode = 1; n_waited = 0;
            if (bus.branch_taken) begin o = 6'b000011; br = 1; end
            else if (hazard_ref()) o = 6'b110001;
        end
        n_stall = bus.clr_stats ? 0 : (o[5] ? sat(m_stall + 1) : m_stall);
        n_flush = bus.clr_stats ? 0 : (br ? sat(m_flush + 1) : m_flush);
        e = {2'(m_mode), busy, o, CNT_W'(m_stall), CNT_W'(m_flush)};
    endtask

    task automatic tick();
        @(posedge clk);
        m_mode = n_mode; m_waited = n_waited; m_stall = n_stall; m_flush = n_flush;
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_valid = 0; bus.id_src1 = '0; bus.id_src2 = '0; bus.id_two_src = 0;
        bus.exe_dest = '0; bus.exe_wb_en = 0; bus.exe_mem_r_en = 0;
        bus.mem_dest = '0; bus.mem_wb_en = 0; bus.branch_taken = 0;
        bus.mem_req = 0; bus.mem_ready = 0; bus.clr_stats = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] e;
        idle_inputs();
        rst = 1'b0;
        m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        #3;
        checks++;
        if (obs !== {2'd0, 1'b0, 6'b000011, CNT_W'(0), CNT_W'(0)}) begin
            failures++; $display("FAIL reset_hold obs=%b exp=%b", obs, {2'd0, 1'b0, 6'b000011, CNT_W'(0), CNT_W'(0)});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1; predict(e);
        checks++;
        if (obs !== e || bus.state !== 2'd0 || bus.flush_if_id !== 1'b1) begin
            failures++; $display("FAIL reset_cycle1 obs=%b exp=%b", obs, e);
        end
        tick();
        #1; predict(e);
        checks++;
        if (obs !== e || bus.state !== 2'd1 || obs[VW-4 -: 6] !== 6'b0) begin
            failures++; $display("FAIL reset_cycle2 obs=%b exp=%b", obs, e);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [VW-1:0] e;
        int s0;
        for (int unsigned v = 0; v < 2; v++) begin
            idle_inputs();
            bus.id_valid = 1; bus.id_src1 = 4'd3; bus.exe_dest = 4'd3;
            bus.exe_wb_en = 1; bus.exe_mem_r_en = (v == 0);
            s0 = m_stall;
            #1; predict(e);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL load_use_%0d obs=%b exp=%b", v, obs, e);
            end
            tick();
            idle_inputs();
            #1; predict(e);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL load_use_after_%0d obs=%b exp=%b", v, obs, e);
            end
            if (v == 0) begin
                checks++;
                if (bus.stall_cnt !== CNT_W'(s0 + 1)) begin
                    failures++; $display("FAIL load_use_stall_cnt got=%0d exp=%0d", bus.stall_cnt, s0 + 1);
                end
            end
            tick();
        end
    endtask

    task automatic test_branch_vs_hazard();
        logic [VW-1:0] e;
        int f0;
        idle_inputs();
        bus.id_valid = 1; bus.id_src1 = 4'd5; bus.exe_dest = 4'd5;
        bus.exe_wb_en = 1; bus.exe_mem_r_en = 1; bus.branch_taken = 1;
        f0 = m_flush;
        #1; predict(e);
        checks++;
        if (obs !== e || bus.freeze_pc !== 1'b0 || bus.flush_if_id !== 1'b1 || bus.flush_id_ex !== 1'b1) begin
            failures++; $display("FAIL branch_over_hazard obs=%b exp=%b", obs, e);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (bus.flush_cnt !== CNT_W'(f0 + 1)) begin
            failures++; $display("FAIL branch_flush_cnt got=%0d exp=%0d", bus.flush_cnt, f0 + 1);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        logic [VW-1:0] e;
        idle_inputs();
        bus.clr_stats = 1;
        #1; predict(e); tick();
        idle_inputs();
        bus.mem_req = 1; bus.mem_ready = 0;
        bus.branch_taken = 1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_ready = 1;
            #1; predict(e);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL mem_wait_cyc%0d obs=%b exp=%b", i, obs, e);
            end
            tick();
        end
        idle_inputs();
        #1; predict(e);
        checks++;
        if (obs !== e || bus.state !== 2'd1 || bus.stall_cnt !== CNT_W'(3) || bus.flush_cnt !== CNT_W'(1)) begin
            failures++; $display("FAIL mem_wait_done obs=%b exp=%b", obs, e);
        end
        tick();
    endtask

    task automatic test_saturation();
        logic [VW-1:0] e;
        idle_inputs();
        bus.id_valid = 1; bus.id_src1 = 4'd7; bus.id_two_src = 1; bus.id_src2 = 4'd9;
        bus.mem_dest = 4'd9; bus.mem_wb_en = 1; bus.exe_dest = 4'd9; bus.exe_wb_en = 1; bus.exe_mem_r_en = 1;
        for (int unsigned i = 0; i < CMAX + 3; i++) begin
            #1; predict(e);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL sat_cyc%0d obs=%b exp=%b", i, obs, e);
            end
            tick();
        end
        checks++;
        if (bus.stall_cnt !== CNT_W'(CMAX)) begin
            failures++; $display("FAIL sat_hold got=%0d exp=%0d", bus.stall_cnt, CMAX);
        end
        bus.clr_stats = 1;
        #1; predict(e); tick();
        bus.clr_stats = 0;
        #1; predict(e);
        checks++;
        if (obs !== e || bus.stall_cnt !== CNT_W'(0)) begin
            failures++; $display("FAIL clr_over_stall obs=%b exp=%b", obs, e);
        end
        tick();
    endtask

    task automatic test_timeout();
        logic [VW-1:0] e;
        idle_inputs();
        bus.mem_req = 1; bus.mem_ready = 0;
        for (int unsigned i = 0; i < TIMEOUT + 3; i++) begin
            #1; predict(e);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL timeout_cyc%0d obs=%b exp=%b", i, obs, e);
            end
            if (i == TIMEOUT + 1) bus.mem_ready = 1;
            tick();
        end
        checks++;
        if (bus.state !== 2'd3 || bus.busy_err !== 1'b1) begin
            failures++; $display("FAIL timeout_sticky state=%0d busy=%b exp state=3 busy=1", bus.state, bus.busy_err);
        end
        #2; rst = 1'b0; #1;
        checks++;
        if (obs !== {2'd0, 1'b0, 6'b000011, CNT_W'(0), CNT_W'(0)}) begin
            failures++; $display("FAIL timeout_async_reset obs=%b exp=%b", obs, {2'd0, 1'b0, 6'b000011, CNT_W'(0), CNT_W'(0)});
        end
        idle_inputs();
        m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic [VW-1:0] e;
        for (int unsigned i = 0; i < 600; i++) begin
            if (m_mode == 3 && $urandom_range(0, 3) == 0) do_reset();
            bus.id_valid = ($urandom_range(0, 3) != 0);
            bus.id_src1 = 4'($urandom_range(0, 3));
            bus.id_src2 = 4'($urandom_range(0, 3));
            bus.id_two_src = 1'($urandom_range(0, 1));
            bus.exe_dest = 4'($urandom_range(0, 3));
            bus.exe_wb_en = 1'($urandom_range(0, 1));
            bus.exe_mem_r_en = 1'($urandom_range(0, 1));
            bus.mem_dest = 4'($urandom_range(0, 3));
            bus.mem_wb_en = 1'($urandom_range(0, 1));
            bus.branch_taken = ($urandom_range(0, 5) == 0);
            bus.mem_req = ($urandom_range(0, 2) == 0);
            bus.mem_ready = ($urandom_range(0, 2) != 0);
            bus.clr_stats = ($urandom_range(0, 31) == 0);
            #1; predict(e);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL random_%0d obs=%b exp=%b", i, obs, e);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_vs_hazard();
        test_mem_wait();
        test_saturation();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the 5-stage ARM core. Each cycle it decides whether the ID/EX pipeline register and its neighbours advance, freeze or are flushed. Inputs are register-dependency hazards, taken branches and the data-memory wait handshake. It also holds a memory-wait watchdog and saturating stall/flush statistics counters.

## Interface
Parameters:
- TIMEOUT, 255: consecutive memory-wait cycles tolerated before the fault state; legal range 1..255.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- id_valid, in, 1: ID stage holds a real instruction.
- id_src1, in, 4: first source register of the ID instruction.
- id_src2, in, 4: second source register of the ID instruction.
- id_two_src, in, 1: id_src2 is actually read.
- exe_dest, exe_wb_en, exe_mem_r_en, in, 4/1/1: destination, writeback enable and load flag of the instruction in EXE.
- mem_dest, mem_wb_en, in, 4/1: destination and writeback enable of the instruction in MEM.
- branch_taken, in, 1: branch resolved taken in EXE.
- mem_req, mem_ready, in, 1/1: data-memory access pending / completes this cycle.
- clr_stats, in, 1: synchronous clear of the statistics counters.
- freeze_pc, freeze_if_id, freeze_id_ex, freeze_exe_mem, out, 1 each: hold the named register.
- flush_if_id, flush_id_ex, out, 1 each: load a bubble into the named register (all enables zero).
- busy_err, out, 1: sticky memory-timeout fault.
- stall_cnt, out, CNT_W: count of cycles with freeze_pc=1.
- flush_cnt, out, CNT_W: count of taken-branch flushes.
- state, out, 2: INIT=0, RUN=1, MEM_WAIT=2, ERROR=3.

## Operation
- **Hazard term hz** (combinational). A source "matches" an older instruction when that instruction's writeback is enabled and its destination equals the source. hz=1 when id_valid is high and id_src1 matches, or id_two_src is high and id_src2 matches. Which older instructions are checked is set under Configuration.
- **INIT** (entered by reset): flush_if_id=flush_id_ex=1, all freezes 0; unconditionally goes to RUN on the next edge.
- **RUN**: rules are applied in priority order; the first one that applies sets the outputs.
  1. mem_req & ~mem_ready: all four freezes 1, no flush; next state MEM_WAIT, wait_cnt<=1. If TIMEOUT=1, next state is ERROR instead.
  2. branch_taken: flush_if_id=flush_id_ex=1, no freeze; flush_cnt+1.
  3. hz: freeze_pc=freeze_if_id=1, flush_id_ex=1 (bubble); instruction in ID is re-presented next cycle.
  4. Otherwise: all outputs 0.
- **MEM_WAIT**:
  - If mem_ready | ~mem_req: outputs per RUN rules 2-4; next state RUN.
  - Else: all freezes 1. If wait_cnt==TIMEOUT-1, next state is ERROR; otherwise wait_cnt+1.
- **ERROR**: all freezes 1, busy_err=1. Left only by reset.
- **Counters**: stall_cnt increments every cycle freeze_pc=1, including ERROR cycles. Both counters saturate at all-ones. clr_stats takes priority over any increment in the same cycle.
- **Branch vs hazard**: a branch overrides a hazard, since the ID instruction is wrong-path. A memory wait overrides both, because EXE is frozen and branch_taken is re-evaluated after the wait.

## Timing
- Reset values: state=INIT, wait_cnt=0, stall_cnt=0, flush_cnt=0, busy_err=0. While rst is low the outputs are the INIT outputs (flush 1, freeze 0).
- INIT lasts exactly one cycle after rst deasserts.
- All freeze/flush outputs are combinational from state and current inputs, so they take effect at the same edge; zero cycles of latency.
- A load-use hazard costs exactly one bubble cycle. A memory wait of N not-ready cycles costs exactly N frozen cycles.
- ERROR is reached at the edge ending the TIMEOUT-th consecutive not-ready cycle.
- An asynchronous reset mid-wait returns to INIT immediately and clears busy_err and the counters.

## Configuration
- FORWARDING_EN defined: only a load in EXE counts (exe_mem_r_en & exe_wb_en & dest match). MEM-stage matches are ignored because the forwarding unit covers them.
- FORWARDING_EN undefined: any match against the EXE destination (exe_wb_en) or the MEM destination (mem_wb_en) counts.

## Test plan
- Reset released -> cycle 1: state=0, flush_if_id=flush_id_ex=1; cycle 2: state=1, all outputs 0.
- id_src1=3, exe_dest=3, exe_wb_en=1, exe_mem_r_en=1 for one cycle -> that cycle freeze_pc=freeze_if_id=flush_id_ex=1; stall_cnt=1 afterwards. With exe_mem_r_en=0: stall only when FORWARDING_EN is undefined.
- branch_taken=1 together with a hazard -> flush_if_id=flush_id_ex=1, freeze_pc=0, flush_cnt increments by 1.
- mem_req=1, mem_ready low for 3 cycles then high -> 3 cycles with all four freezes 1, state=2 on cycles 2-3, state=1 after; stall_cnt=3.
- TIMEOUT=4, mem_ready held low -> state=3 after the 4th not-ready edge, busy_err=1 sticky; rst low returns state=0 and busy_err=0.
- stall_cnt at all-ones plus a further stall -> remains all-ones; clr_stats with a simultaneous stall -> stall_cnt=0.
